// File: rtl/fpu_result_buffer.sv
// FPU result buffer: captures FPU result pulses into a FIFO, issues credits
// so the FPU can never overflow it, and hands results to write-back via valid/ready.
module fpu_result_buffer #(
  parameter int unsigned C_OP   = 32,
  parameter int unsigned C_FLAG = 9,
  parameter int unsigned C_TAG  = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RBI,
  input  logic                         Issue_SI,
  output logic                         IssueGnt_SO,
  input  logic                         Req_SI,
  input  logic [C_OP-1:0]              Result_DI,
  input  logic [C_FLAG-1:0]            Flags_DI,
  input  logic [C_TAG-1:0]             Tag_DI,
  output logic                         Valid_SO,
  input  logic                         Ready_SI,
  output logic [C_OP-1:0]              Result_DO,
  output logic [C_FLAG-1:0]            Flags_DO,
  output logic [C_TAG-1:0]             Tag_DO,
  output logic [$clog2(DEPTH+1)-1:0]   Count_SO,
  output logic                         Error_SO
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [C_TAG-1:0]  tag;
    logic [C_FLAG-1:0] flags;
    logic [C_OP-1:0]   result;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, out_q;
  logic            valid_q, error_q;

  logic            pop, push, full, gnt, inc;
  logic [CW-1:0]   count_d, out_d;
  logic            error_d;
  logic [AW-1:0]   rd_idx, wr_idx;

  // Handshake, credit and occupancy next-state logic.
  always_comb begin
    pop     = 1'b0;
    push    = 1'b0;
    full    = 1'b0;
    gnt     = 1'b0;
    inc     = 1'b0;
    count_d = count_q;
    out_d   = out_q;
    error_d = error_q;

    pop     = valid_q & Ready_SI;
    full    = (count_q == CW'(DEPTH));
    // A pop frees the head slot this cycle, so a push into a full FIFO is still safe.
    push    = Req_SI & (~full | pop);
    // Popping returns a credit that can be spent by an issue in the same cycle.
    gnt     = (out_q < CW'(DEPTH)) | pop;
    inc     = Issue_SI & gnt;
    count_d = count_q + CW'(push) - CW'(pop);
    out_d   = out_q + CW'(inc) - CW'(pop);
    error_d = error_q | (Issue_SI & ~gnt) | (Req_SI & ~push);
  end

  // Pointer, occupancy, credit and sticky error registers.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
      out_q   <= out_d;
      valid_q <= (count_d != '0);
      error_q <= error_d;
    end
  end

  assign wr_idx = wptr_q[AW-1:0];
  assign rd_idx = rptr_q[AW-1:0];

  // Entry storage; cleared on reset so data outputs read zero afterwards.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_idx] <= {Tag_DI, Flags_DI, Result_DI};
    end
  end

  assign IssueGnt_SO = gnt;
  assign Valid_SO    = valid_q;
  assign Count_SO    = count_q;
  assign Error_SO    = error_q;
  assign Result_DO   = mem_q[rd_idx].result;
  assign Flags_DO    = mem_q[rd_idx].flags;
  assign Tag_DO      = mem_q[rd_idx].tag;

endmodule
